// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results through and serialises
// loads/stores over a byte-wide RAM port, stalling upstream while busy.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              valid_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       store_data_i,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic              stall_req_o,
  output logic              valid_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic [2:0]        f3;
  logic [2:0]        nbytes;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] a_q;
  logic [ADDR_W-1:0] a_cur;
  logic [31:0]       sdata;
  logic [31:0]       lbuf, lbuf_n;
  logic [31:0]       ext;
  logic [7:0]        dout_q;
  logic [7:0]        byte_cur;
  logic [4:0]        wd_q;
  logic              wreg_q;
  logic              is_mem;
  logic              drive;
  logic              ld_done;
  logic              st_done;

  assign is_mem  = (opcode_i == OP_LOAD) || (opcode_i == OP_STORE);
  assign nbytes  = (f3[1:0] == 2'b00) ? 3'd1 :
                   (f3[1:0] == 2'b01) ? 3'd2 : 3'd4;
  assign a_cur   = addr + ADDR_W'(cnt);
  assign byte_cur = sdata[{cnt[1:0], 3'b000} +: 8];
  assign ld_done = (state == LOAD) && (cnt == nbytes);
  assign st_done = (state == STORE) && (cnt == 3'(nbytes - 3'd1));
  assign drive   = ((state == LOAD) && (cnt < nbytes)) ||
                   (state == STORE);

  // While frozen, keep presenting the last address so read data stays aligned.
  assign mem_a    = (drive && rdy) ? a_cur : a_q;
  assign mem_dout = ((state == STORE) && rdy) ? byte_cur : dout_q;
  assign mem_wr   = rdy && (state == STORE);

  always_comb begin
    stall_req_o = 1'b0;
    unique case (state)
      IDLE:    stall_req_o = valid_i && is_mem;
      LOAD:    stall_req_o = cnt < nbytes;
      STORE:   stall_req_o = cnt < 3'(nbytes - 3'd1);
      default: stall_req_o = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (valid_i && is_mem) begin
          state_n = (opcode_i == OP_LOAD) ? LOAD : STORE;
          cnt_n   = 3'd0;
        end
      end
      LOAD: begin
        cnt_n = cnt + 3'd1;
        if (ld_done) state_n = IDLE;
      end
      STORE: begin
        cnt_n = cnt + 3'd1;
        if (st_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    lbuf_n = lbuf;
    if (state == LOAD) begin
      case (cnt)
        3'd1:    lbuf_n[7:0]   = mem_din;
        3'd2:    lbuf_n[15:8]  = mem_din;
        3'd3:    lbuf_n[23:16] = mem_din;
        3'd4:    lbuf_n[31:24] = mem_din;
        default: lbuf_n = lbuf;
      endcase
    end
  end

  always_comb begin
    ext = lbuf_n;
    unique case (1'b1)
      f3[1:0] == 2'b00:
        ext = {{24{~f3[2] & lbuf_n[7]}}, lbuf_n[7:0]};
      f3[1:0] == 2'b01:
        ext = {{16{~f3[2] & lbuf_n[15]}}, lbuf_n[15:0]};
      default:
        ext = lbuf_n;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      f3      <= 3'd0;
      addr    <= '0;
      sdata   <= 32'd0;
      lbuf    <= 32'd0;
      wd_q    <= 5'd0;
      wreg_q  <= 1'b0;
      a_q     <= '0;
      dout_q  <= 8'd0;
      valid_o <= 1'b0;
      wd_o    <= 5'd0;
      wreg_o  <= 1'b0;
      wdata_o <= 32'd0;
    end else if (rdy) begin
      state   <= state_n;
      cnt     <= cnt_n;
      lbuf    <= lbuf_n;
      valid_o <= 1'b0;
      if (drive) a_q <= a_cur;
      if (state == STORE) dout_q <= byte_cur;
      unique case (state)
        IDLE: begin
          if (valid_i && is_mem) begin
            f3     <= funct3_i;
            addr   <= mem_addr_i;
            sdata  <= store_data_i;
            wd_q   <= wd_i;
            wreg_q <= wreg_i;
          end else if (valid_i) begin
            valid_o <= 1'b1;
            wd_o    <= wd_i;
            wreg_o  <= wreg_i;
            wdata_o <= wdata_i;
          end
        end
        LOAD: begin
          if (ld_done) begin
            valid_o <= 1'b1;
            wd_o    <= wd_q;
            wreg_o  <= wreg_q;
            wdata_o <= ext;
          end
        end
        STORE: begin
          if (st_done) begin
            valid_o <= 1'b1;
            wd_o    <= wd_q;
            wreg_o  <= wreg_q;
            wdata_o <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
